// File: rtl/sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks a synchronous command ROM after reset and feeds each {rega, value}
// pair, together with a fixed device ID, to the SCCB sender's command port.
// Each command stays on the port through the sender's latch window. Table
// words 16'hFFFF (end) and 16'hFFF0 (delay) are interpreted in-band.
// Completion is reported on done/busy, and resend replays the table.
//
// Build option:
//   SCCB_DELAY_CMD_EN  defined   : 16'hFFF0 waits DELAY_CYCLES before the next
//                                   entry (camera settling after soft reset).
//                      undefined : 16'hFFF0 is skipped. No delay hardware.
//
// Ports:
//   clk       in   system clock
//   clr_n     in   asynchronous active-low reset
//   resend    in   replay the table from entry 0 (only acted on when done)
//   cmd_addr  out  ROM address (registered)
//   cmd_data  in   ROM word {rega, value}, valid one cycle after cmd_addr
//   send      out  command request to the sender
//   taken     in   one-cycle accept pulse from the sender
//   id        out  SCCB write address, constant DEV_ID
//   rega      out  register address of the current command
//   value     out  register data of the current command
//   busy      out  high whenever the table is not finished
//   done      out  table finished
// -----------------------------------------------------------------------------
module sccb_config_sequencer #(
    parameter logic [7:0]  DEV_ID       = 8'h42,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [15:0] BOOT_CYCLES  = 16'd50000,
    parameter logic [8:0]  HOLD_CYCLES  = 9'd256,
    parameter logic [23:0] DELAY_CYCLES = 24'd500000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              resend,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_data,
    output logic              send,
    input  logic              taken,
    output logic [7:0]        id,
    output logic [7:0]        rega,
    output logic [7:0]        value,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_HOLD,
`ifdef SCCB_DELAY_CMD_EN
        ST_DELAY,
`endif
        ST_DONE
    } state_e;

    localparam logic [15:0]       CMD_END   = 16'hFFFF;
    localparam logic [15:0]       CMD_DELAY = 16'hFFF0;
    // Counters run 0 .. N-1 and compare for equality with the last value.
    localparam logic [15:0]       BOOT_LAST = BOOT_CYCLES - 16'd1;
    localparam logic [15:0]       HOLD_LAST = {7'd0, HOLD_CYCLES - 9'd1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;      // shared by BOOT and HOLD
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rega_q, rega_d;
    logic [7:0]        value_q, value_d;

`ifdef SCCB_DELAY_CMD_EN
    localparam logic [23:0] DELAY_LAST = DELAY_CYCLES - 24'd1;
    logic [23:0]       dly_q, dly_d;
`else
    // DELAY_CYCLES has no hardware in this build; the empty block only keeps
    // the parameter referenced so both builds share one parameter list.
    if (DELAY_CYCLES == 24'd0) begin : g_delay_unused
    end
`endif

    // Finishing an entry advances the address, except at the top of the ROM
    // where the table is treated as ended instead of wrapping to entry 0.
    logic              at_last;
    logic [ADDR_W-1:0] addr_next;
    state_e            after_entry;

    assign at_last     = (addr_q == ADDR_LAST);
    assign addr_next   = at_last ? addr_q : addr_q + ADDR_ONE;
    assign after_entry = at_last ? ST_DONE : ST_FETCH;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
            addr_q  <= '0;
            rega_q  <= '0;
            value_q <= '0;
`ifdef SCCB_DELAY_CMD_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rega_q  <= rega_d;
            value_q <= value_d;
`ifdef SCCB_DELAY_CMD_EN
            dly_q   <= dly_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rega_d  = rega_q;
        value_d = value_q;
`ifdef SCCB_DELAY_CMD_EN
        dly_d   = dly_q;
`endif
        case (state_q)
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // One cycle for the ROM to present the word at addr_q.
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (cmd_data == CMD_END) begin
                    state_d = ST_DONE;
                end else if (cmd_data == CMD_DELAY) begin
`ifdef SCCB_DELAY_CMD_EN
                    dly_d   = '0;
                    state_d = ST_DELAY;
`else
                    addr_d  = addr_next;
                    state_d = after_entry;
`endif
                end else begin
                    rega_d  = cmd_data[15:8];
                    value_d = cmd_data[7:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (taken) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            // The sender latches the command at its divider wrap well after
            // taken, so the port is held for the whole window.
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    addr_d  = addr_next;
                    state_d = after_entry;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SCCB_DELAY_CMD_EN
            ST_DELAY: begin
                if (dly_q == DELAY_LAST) begin
                    dly_d   = '0;
                    addr_d  = addr_next;
                    state_d = after_entry;
                end else begin
                    dly_d = dly_q + 24'd1;
                end
            end
`endif
            ST_DONE: begin
                // Replays skip BOOT: the camera is already powered up.
                if (resend) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the state register so clr_n drops send at once
    // -------------------------------------------------------------------------
    always_comb begin
        send = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state_q)
            ST_SEND, ST_HOLD: send = 1'b1;
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign id       = DEV_ID;
    assign cmd_addr = addr_q;
    assign rega     = rega_q;
    assign value    = value_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_config_sequencer
//
// Directed bench for sccb_config_sequencer with a 4-entry ROM (ADDR_W=2),
// BOOT_CYCLES=4, HOLD_CYCLES=3, DELAY_CYCLES=10. The main process loads ROM
// tables and pushes the expected bus writes onto a queue; a monitor pops one
// entry per rising edge of send and checks the command, the number of low
// cycles before it and the length of the send pulse. A driver answers each
// send with a taken pulse unless told otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccb_config_sequencer;

    localparam int ADDR_W   = 2;
    localparam int BOOT     = 4;
    localparam int HOLD     = 3;
    localparam int TAKE_LAT = 2;              // taken asserted on the 2nd send-high sample
    localparam int SEND_LEN = TAKE_LAT + HOLD; // SEND cycles + HOLD cycles
    localparam int FIRST_GAP = BOOT + 2;       // BOOT, FETCH, DECODE after reset
    localparam int NEXT_GAP  = 2;              // FETCH, DECODE between writes
`ifdef SCCB_DELAY_CMD_EN
    // FETCH, DECODE(FFF0), 10 x DELAY, FETCH, DECODE
    localparam int MARK_GAP = 2 + 10 + 2;
`else
    // FETCH, DECODE(FFF0 skipped), FETCH, DECODE
    localparam int MARK_GAP = 4;
`endif

    logic              clk;
    logic              clr_n;
    logic              resend;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_data;
    logic              send;
    logic              taken;
    logic [7:0]        id;
    logic [7:0]        rega;
    logic [7:0]        value;
    logic              busy;
    logic              done;

    sccb_config_sequencer #(
        .DEV_ID       (8'h42),
        .ADDR_W       (ADDR_W),
        .BOOT_CYCLES  (16'd4),
        .HOLD_CYCLES  (9'd3),
        .DELAY_CYCLES (24'd10)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .resend   (resend),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .send     (send),
        .taken    (taken),
        .id       (id),
        .rega     (rega),
        .value    (value),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: word appears one cycle after the address.
    logic [15:0] rom [4];
    always @(posedge clk) cmd_data <= rom[cmd_addr];

    typedef struct {
        logic [7:0] rega;
        logic [7:0] value;
        int         gap;   // low samples before the rise, -1 = not checked
        int         high;  // high samples of the pulse,   -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic auto_take = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] r, input logic [7:0] v, input int gap, input int high);
        exp_t e;
        e.rega  = r;
        e.value = v;
        e.gap   = gap;
        e.high  = high;
        exp_q.push_back(e);
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic wait_send(input logic lvl, input int budget, input string name);
        for (int i = 0; i < budget && send !== lvl; i++) @(negedge clk);
        check(name, send, lvl);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
        check(name, done, 1'b1);
    endtask

    task automatic pulse_resend();
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // taken driver
    // -------------------------------------------------------------------------
    initial begin
        logic drv_prev;
        drv_prev = 1'b0;
        taken    = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_take && clr_n && send && !drv_prev) begin
                repeat (TAKE_LAT - 1) @(negedge clk);
                taken = 1'b1;
                @(negedge clk);
                taken = 1'b0;
            end
            drv_prev = send;
        end
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic        mon_prev;
        int          low_cnt;
        int          high_cnt;
        int          pend_high;
        logic [15:0] held;
        exp_t        e;
        mon_prev  = 1'b0;
        low_cnt   = 0;
        high_cnt  = 0;
        pend_high = -1;
        held      = '0;
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                mon_prev  = 1'b0;
                low_cnt   = 0;
                high_cnt  = 0;
                pend_high = -1;
            end else if (send && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got rega=0x%0h value=0x%0h, want no write",
                             rega, value);
                    pend_high = -1;
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rega", rega, e.rega);
                    check("wr_value", value, e.value);
                    if (e.gap >= 0) check("wr_gap", low_cnt, e.gap);
                    pend_high = e.high;
                end
                held     = {rega, value};
                high_cnt = 1;
                mon_prev = 1'b1;
            end else if (send) begin
                check("cmd_stable", {rega, value}, held);
                high_cnt++;
            end else begin
                if (mon_prev) begin
                    if (pend_high >= 0) check("send_len", high_cnt, pend_high);
                    low_cnt = 0;
                end
                low_cnt++;
                pend_high = -1;
                mon_prev  = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        clr_n  = 1'b1;
        resend = 1'b0;
        load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
        #2 clr_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_send", send, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_addr", cmd_addr, 0);
        check("rst_rega", rega, 8'h00);
        check("rst_value", value, 8'h00);
        check("id", id, 8'h42);

        // A: single write then end marker.
        push_exp(8'h12, 8'h80, FIRST_GAP, SEND_LEN);
        release_reset();
        // A taken during BOOT must be ignored.
        @(negedge clk);
        taken = 1'b1;
        @(negedge clk);
        taken = 1'b0;
        wait_send(1'b1, 50, "a_send_rise");
        wait_send(1'b0, 50, "a_send_fall");
        check("a_fetch_addr", cmd_addr, 1);
        check("a_fetch_done", done, 1'b0);
        @(negedge clk);
        check("a_decode_done", done, 1'b0);
        @(negedge clk);
        check("a_done", done, 1'b1);
        check("a_busy", busy, 1'b0);
        check("a_addr", cmd_addr, 1);
        check("a_all_seen", exp_q.size(), 0);

        // B: delay marker between two writes; resend mid-sequence ignored.
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        load_rom(16'h1280, 16'hFFF0, 16'h1204, 16'hFFFF);
        push_exp(8'h12, 8'h80, FIRST_GAP, SEND_LEN);
        push_exp(8'h12, 8'h04, MARK_GAP, SEND_LEN);
        release_reset();
        wait_send(1'b1, 50, "b_send_rise");
        pulse_resend();
        wait_done(200, "b_done");
        check("b_addr", cmd_addr, 3);
        check("b_all_seen", exp_q.size(), 0);

        // Replay after done: address returns to 0, send two cycles later.
        push_exp(8'h12, 8'h80, -1, SEND_LEN);
        push_exp(8'h12, 8'h04, MARK_GAP, SEND_LEN);
        pulse_resend();
        check("rs_addr", cmd_addr, 0);
        check("rs_done", done, 1'b0);
        check("rs_send0", send, 1'b0);
        @(negedge clk);
        check("rs_send1", send, 1'b0);
        @(negedge clk);
        check("rs_send2", send, 1'b1);
        wait_done(200, "rs_done_again");
        check("rs_addr_end", cmd_addr, 3);

        // C: no end marker; the top address ends the table without wrapping.
        load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        push_exp(8'h11, 8'h11, -1, SEND_LEN);
        push_exp(8'h22, 8'h22, NEXT_GAP, SEND_LEN);
        push_exp(8'h33, 8'h33, NEXT_GAP, SEND_LEN);
        push_exp(8'h44, 8'h44, NEXT_GAP, SEND_LEN);
        pulse_resend();
        wait_done(300, "c_done");
        check("c_addr", cmd_addr, 3);
        repeat (5) @(negedge clk);
        check("c_still_done", done, 1'b1);
        check("c_all_seen", exp_q.size(), 0);

        // D: taken withheld; the command must stall on the port.
        load_rom(16'h5566, 16'hFFFF, 16'h0000, 16'h0000);
        auto_take = 1'b0;
        push_exp(8'h55, 8'h66, -1, -1);
        pulse_resend();
        wait_send(1'b1, 20, "d_send_rise");
        repeat (20) @(negedge clk);
        check("d_send_held", send, 1'b1);
        check("d_addr_held", cmd_addr, 0);
        check("d_rega", rega, 8'h55);
        check("d_value", value, 8'h66);
        check("d_busy", busy, 1'b1);
        taken = 1'b1;
        @(negedge clk);
        taken     = 1'b0;
        auto_take = 1'b1;
        wait_done(50, "d_done");
        check("d_addr", cmd_addr, 1);

        // E: reset during HOLD aborts at once and repeats the boot wait.
        load_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
        push_exp(8'h12, 8'h80, -1, -1);
        pulse_resend();
        wait_send(1'b1, 20, "e_send_rise");
        repeat (TAKE_LAT) @(negedge clk);
        check("e_in_hold", send, 1'b1);
        #1 clr_n = 1'b0;
        #1;
        check("e_async_send", send, 1'b0);
        check("e_async_done", done, 1'b0);
        check("e_async_busy", busy, 1'b1);
        check("e_async_rega", rega, 8'h00);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_exp(8'h12, 8'h80, FIRST_GAP, SEND_LEN);
        release_reset();
        check("e_addr", cmd_addr, 0);
        wait_done(100, "e_done");
        check("e_addr_end", cmd_addr, 1);
        check("e_all_seen", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
